// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - word stream in and byte memory write port of the program loader
// Purpose: bundles the loader's two bus-style ports.
//   in_valid/in_word/in_ready : 32-bit instruction word stream (valid/ready)
//   mem_we/mem_addr/mem_wdata : byte write port into the instruction memory
// master = the loader (stream sink, memory writer); slave = its environment.
interface imem_loader_if;
   logic        in_valid;
   logic [31:0] in_word;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;

   modport master (
      input  in_valid, in_word,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_word,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads 32-bit words into a byte memory as four big-endian byte writes
// Purpose: on start, accepts word_count words from the stream and writes each
// one as mem[a]=w[31:24] .. mem[a+3]=w[7:0], one byte per cycle.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start_i        : one-cycle load request, honoured only in IDLE
//   base_addr_i    : byte address of the first word (must be 4-aligned)
//   word_count_i   : number of words to load
//   busy_o         : load in progress (WAIT_WORD or WRITE)
//   done_o         : one-cycle completion pulse
//   err_o          : sticky error (misaligned base or memory overflow)
//   bus            : word stream in / byte write port out (master side)
module imem_loader #(
   parameter int unsigned MEM_BYTES = 512,
   parameter int unsigned CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [31:0]      base_addr_i,
   input  logic [CNT_W-1:0] word_count_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   imem_loader_if.master    bus
);

   typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;

   localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

   state_t           state_q;
   logic [31:0]      addr_q;
   logic [31:0]      word_q;
   logic [CNT_W-1:0] remain_q;
   logic [1:0]       k_q;
   logic             err_q;
   logic [32:0]      end_addr;

   // Computed one bit wider so a word near the top of the 32-bit space
   // cannot wrap around and slip past the bounds check.
   assign end_addr = {1'b0, addr_q} + 33'd3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         word_q   <= '0;
         remain_q <= '0;
         k_q      <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  err_q    <= 1'b0;
                  addr_q   <= base_addr_i;
                  remain_q <= word_count_i;
                  if (base_addr_i[1:0] != 2'b00) begin
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else if (word_count_i == '0) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= WAIT_WORD;
                  end
               end
            end
            WAIT_WORD: begin
               if (bus.in_valid) begin
                  word_q <= bus.in_word;
                  k_q    <= 2'd0;
                  // The word is consumed even when it does not fit; the
                  // load is then aborted without touching memory.
                  if (end_addr > LAST_BYTE) begin
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= WRITE;
                  end
               end
            end
            WRITE: begin
               k_q <= k_q + 2'd1;
               if (k_q == 2'd3) begin
                  addr_q   <= addr_q + 32'd4;
                  remain_q <= remain_q - CNT_W'(1);
                  state_q  <= (remain_q == CNT_W'(1)) ? DONE : WAIT_WORD;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // All outputs decode directly from flops, so none depends on an input.
   assign bus.in_ready = (state_q == WAIT_WORD);
   assign bus.mem_we   = (state_q == WRITE);
   assign bus.mem_addr = (state_q == WRITE) ? addr_q + {30'd0, k_q} : 32'd0;
   assign busy_o       = (state_q == WAIT_WORD) || (state_q == WRITE);
   assign done_o       = (state_q == DONE);
   assign err_o        = err_q;

   always_comb begin
      bus.mem_wdata = 8'd0;
      if (state_q == WRITE) begin
         case (k_q)
            2'd0:    bus.mem_wdata = word_q[31:24];
            2'd1:    bus.mem_wdata = word_q[23:16];
            2'd2:    bus.mem_wdata = word_q[15:8];
            default: bus.mem_wdata = word_q[7:0];
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed table-driven bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [31:0] base_addr_i;
   logic [8:0]  word_count_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   imem_loader_if bus();

   imem_loader #(.MEM_BYTES(512), .CNT_W(9)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .word_count_i (word_count_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .bus          (bus)
   );

   typedef struct {
      string       name;
      logic [31:0] base;
      logic [8:0]  cnt;
      logic [31:0] w0;
      logic [31:0] w1;
      int          nw;       // words the bench offers
      int          delay;    // cycles before in_valid first rises
      int          restart;  // cycle of a spurious start pulse, -1 none
      int          exp_wr;   // expected byte writes
      logic [31:0] addr0;    // expected address of first byte
      logic [63:0] bytes;    // expected byte stream, first byte in [63:56]
      logic        exp_err;
      int          exp_done; // cycle index of done (0 = first cycle after start)
      int          exp_rdy;  // cycles with in_ready high
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_load(input vec_t v);
      int          wr_n = 0;
      int          rdy_n = 0;
      int          ovl = 0;
      int          done_n = 0;
      int          done_idx = -1;
      int          widx = 0;
      logic        err_at = 1'bx;
      logic        busy_at = 1'bx;
      logic [31:0] wa[16];
      logic [7:0]  wd[16];
      logic [63:0] eb;

      @(negedge clk);
      start_i      = 1'b1;
      base_addr_i  = v.base;
      word_count_i = v.cnt;
      @(negedge clk);
      start_i = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (bus.mem_we) begin
            if (wr_n < 16) begin
               wa[wr_n] = bus.mem_addr;
               wd[wr_n] = bus.mem_wdata;
            end
            wr_n++;
         end
         if (bus.in_ready) rdy_n++;
         if (bus.in_ready && bus.mem_we) ovl++;
         if (done_o) begin
            if (done_n == 0) begin
               done_idx = i;
               err_at   = err_o;
               busy_at  = busy_o;
            end
            done_n++;
         end
         if (i == v.restart) begin
            start_i      = 1'b1;
            base_addr_i  = 32'h100;
            word_count_i = 9'd7;
         end else begin
            start_i = 1'b0;
         end
         if (widx < v.nw && i >= v.delay) begin
            bus.in_valid = 1'b1;
            bus.in_word  = (widx == 0) ? v.w0 : v.w1;
         end else begin
            bus.in_valid = 1'b0;
            bus.in_word  = 32'h0;
         end
         if (bus.in_valid && bus.in_ready) widx++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      start_i      = 1'b0;

      chk({v.name, " writes"}, 32'(wr_n), 32'(v.exp_wr));
      eb = v.bytes;
      for (int j = 0; j < v.exp_wr && j < wr_n && j < 8; j++) begin
         chk($sformatf("%s addr[%0d]", v.name, j), wa[j], v.addr0 + 32'(j));
         chk($sformatf("%s data[%0d]", v.name, j), {24'd0, wd[j]}, {24'd0, eb[63-8*j -: 8]});
      end
      chk({v.name, " done pulses"}, 32'(done_n), 32'd1);
      chk({v.name, " done cycle"}, 32'(done_idx), 32'(v.exp_done));
      chk({v.name, " err at done"}, {31'd0, err_at}, {31'd0, v.exp_err});
      chk({v.name, " busy at done"}, {31'd0, busy_at}, 32'd0);
      chk({v.name, " ready cycles"}, 32'(rdy_n), 32'(v.exp_rdy));
      chk({v.name, " we while ready"}, 32'(ovl), 32'd0);
      chk({v.name, " err sticky"}, {31'd0, err_o}, {31'd0, v.exp_err});
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      chk({tag, " mem_we"}, {31'd0, bus.mem_we}, 32'd0);
      chk({tag, " mem_addr"}, bus.mem_addr, 32'd0);
      chk({tag, " mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
      chk({tag, " busy"}, {31'd0, busy_o}, 32'd0);
      chk({tag, " done"}, {31'd0, done_o}, 32'd0);
      chk({tag, " err"}, {31'd0, err_o}, 32'd0);
   endtask

   initial begin
      vec_t rv;

      //          name          base      cnt  w0            w1            nw dl rs  wr addr0    bytes                  err done rdy
      tbl[0] = '{"nominal",    32'd0,    9'd2, 32'h24010000, 32'h24020004, 2, 0, 3,  8, 32'd0,   64'h24010000_24020004, 1'b0, 10, 2};
      tbl[1] = '{"backpress",  32'h40,   9'd1, 32'hDEADBEEF, 32'h0,        1, 3, -1, 4, 32'h40,  64'hDEADBEEF_00000000, 1'b0,  8, 4};
      tbl[2] = '{"zero cnt",   32'h10,   9'd0, 32'h0,        32'h0,        0, 0, -1, 0, 32'h10,  64'h0,                 1'b0,  0, 0};
      tbl[3] = '{"misalign",   32'h6,    9'd1, 32'h12345678, 32'h0,        1, 0, -1, 0, 32'h6,   64'h0,                 1'b1,  0, 0};
      tbl[4] = '{"err clear",  32'd0,    9'd1, 32'h11223344, 32'h0,        1, 0, -1, 4, 32'd0,   64'h11223344_00000000, 1'b0,  5, 1};
      tbl[5] = '{"overflow",   32'd508,  9'd2, 32'hAABBCCDD, 32'h01020304, 2, 0, -1, 4, 32'd508, 64'hAABBCCDD_00000000, 1'b1,  6, 2};
      tbl[6] = '{"mis cnt0",   32'h3,    9'd0, 32'h0,        32'h0,        0, 0, -1, 0, 32'h3,   64'h0,                 1'b1,  0, 0};
      tbl[7] = '{"top fit",    32'd504,  9'd2, 32'hCAFEF00D, 32'h12345678, 2, 1, -1, 8, 32'd504, 64'hCAFEF00D_12345678, 1'b0, 11, 3};

      rst_n        = 1'b0;
      start_i      = 1'b0;
      base_addr_i  = 32'h0;
      word_count_i = 9'd0;
      bus.in_valid = 1'b0;
      bus.in_word  = 32'h0;
      #1;
      chk_idle_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 8; t++) run_load(tbl[t]);

      // Reset in the middle of the third byte of a word.
      @(negedge clk);
      start_i      = 1'b1;
      base_addr_i  = 32'h0;
      word_count_i = 9'd2;
      @(negedge clk);
      start_i      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_word  = 32'h55667788;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst k2 we", {31'd0, bus.mem_we}, 32'd1);
      chk("midrst k2 addr", bus.mem_addr, 32'd2);
      chk("midrst k2 data", {24'd0, bus.mem_wdata}, 32'h77);
      #1 rst_n = 1'b0;
      #1;
      chk_idle_outputs("midrst async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("after rst");

      rv = '{"post rst", 32'h20, 9'd1, 32'h99AABBCC, 32'h0, 1, 0, -1, 4, 32'h20,
             64'h99AABBCC_00000000, 1'b0, 5, 1};
      run_load(rv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
